// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extend pipeline: ImmSrc format codes
// and elaboration-time parameter legality checks.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder. Input holds instr[31:7]; instr[6:0]
// are taken as zero, so instr[k] maps to i_in[k-7].
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [24:0]     i_in,
  input  logic [2:0]      i_imm_src,
  output logic [XLEN-1:0] o_imm,
  output logic            o_err
);

  logic [31:0] w_imm32;
  logic        w_sign;

  assign w_sign = i_in[24];

  always_comb begin
    w_imm32 = '0;
    o_err   = 1'b0;
    case (i_imm_src)
      IMM_I:   w_imm32 = {{20{w_sign}}, i_in[24:13]};
      IMM_S:   w_imm32 = {{20{w_sign}}, i_in[24:18], i_in[4:0]};
      IMM_B:   w_imm32 = {{19{w_sign}}, w_sign, i_in[0], i_in[23:18], i_in[4:1], 1'b0};
      IMM_J:   w_imm32 = {{11{w_sign}}, w_sign, i_in[12:5], i_in[13], i_in[23:14], 1'b0};
      IMM_U:   w_imm32 = {i_in[24:5], 12'b0};
      default: o_err   = 1'b1;
    endcase
  end

  // Every legal format is already sign-correct at 32 bits; widen from bit 31.
  assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate decode followed by a DEPTH-entry valid/ready output queue.
// Outputs come only from registered queue state; idle outputs read as zero.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("imm_extend_pipe: DEPTH must be a power of two >= 2");
  end

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_err;
  logic             w_push;
  logic             w_pop;

  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic             r_err [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .i_in      (in),
    .i_imm_src (ImmSrc),
    .o_imm     (w_dec_imm),
    .o_err     (w_dec_err)
  );

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);

  // Reset and flush override both handshakes.
  assign w_push = in_valid && in_ready && !rst && !flush;
  assign w_pop  = out_valid && out_ready && !rst && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm[r_wptr] <= w_dec_imm;
      r_tag[r_wptr] <= in_tag;
      r_err[r_wptr] <= w_dec_err;
    end
  end

  assign out     = out_valid ? r_imm[r_rptr] : '0;
  assign out_tag = out_valid ? r_tag[r_rptr] : '0;
  assign imm_err = out_valid ? r_err[r_rptr] : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 instance with a scoreboard on its output,
// plus an XLEN=64 instance for wide sign-extension checks.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // XLEN=32 instance
  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_imm_err;
  logic [24:0] a_in;
  logic [2:0]  a_src;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out;

  // XLEN=64 instance
  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_imm_err;
  logic [24:0] b_in;
  logic [2:0]  b_src;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [63:0] b_out;

  imm_extend_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut32 (
    .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in(a_in), .ImmSrc(a_src), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out(a_out), .out_tag(a_out_tag), .imm_err(a_imm_err)
  );

  imm_extend_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) dut64 (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in(b_in), .ImmSrc(b_src), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out(b_out), .out_tag(b_out_tag), .imm_err(b_imm_err)
  );

  // Reference decode, written arithmetically: returns {err, imm32}.
  function automatic logic [32:0] model(input logic [24:0] v, input logic [2:0] s);
    logic [31:0]        x;
    logic signed [31:0] sx;
    logic [31:0]        r;
    logic               e;
    x  = {v, 7'b0};
    sx = x;
    e  = 1'b0;
    case (s)
      3'd0:    r = 32'(sx >>> 20);
      3'd1:    r = (32'(sx >>> 25) << 5) | 32'(x[11:7]);
      3'd2:    r = (32'(sx >>> 31) << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      3'd3:    r = (32'(sx >>> 31) << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      3'd4:    r = x & 32'hFFFFF000;
      default: begin r = 32'h0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  logic [37:0] sb [$];

  // Scoreboard: pop/compare on a completed output handshake, push on accept.
  always @(negedge clk) begin
    logic [37:0] exp_e;
    logic [32:0] m;
    if (a_rst || a_flush) begin
      sb.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        pops++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got={err=%b tag=%0d out=%h} required=nothing queued", a_imm_err, a_out_tag, a_out);
        end else begin
          exp_e = sb.pop_front();
          if ({a_imm_err, a_out_tag, a_out} !== exp_e) begin
            bad++;
            $display("FAIL sb_entry got={err=%b tag=%0d out=%h} required={err=%b tag=%0d out=%h}",
                     a_imm_err, a_out_tag, a_out, exp_e[37], exp_e[36:32], exp_e[31:0]);
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        m = model(a_in, a_src);
        sb.push_back({m[32], a_in_tag, m[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    a_out_ready = 1'b1;
    while ((sb.size() != 0 || a_out_valid) && n < 20) begin
      tick();
      n++;
    end
    a_out_ready = 1'b0;
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL drain_timeout got=%0d entries left required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_in = '0; a_src = '0; a_in_tag = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in = '0; b_src = '0; b_in_tag = '0;
    repeat (3) tick();
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b required=1", a_in_ready); end
    total++; if (a_out !== 32'h0)      begin bad++; $display("FAIL reset_out got=%h required=0", a_out); end
    total++; if (a_out_tag !== 5'h0)   begin bad++; $display("FAIL reset_out_tag got=%h required=0", a_out_tag); end
    total++; if (a_imm_err !== 1'b0)   begin bad++; $display("FAIL reset_imm_err got=%b required=0", a_imm_err); end
    total++; if ({b_out_valid, b_in_ready, b_out} !== {1'b0, 1'b1, 64'h0})
      begin bad++; $display("FAIL reset64 got=%b/%b/%h required=0/1/0", b_out_valid, b_in_ready, b_out); end
  endtask

  task automatic test_formats();
    logic [31:0] vi [6] = '{32'hFFF00093, 32'h00512423, 32'hFE000EE3, 32'h001000EF, 32'h123450B7, 32'h12345678};
    logic [2:0]  vs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] ve [6] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h00000800, 32'h12345000, 32'h0};
    logic        vr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] w;
    for (int i = 0; i < 6; i++) begin
      w = vi[i];
      a_in = w[31:7]; a_src = vs[i]; a_in_tag = 5'(i + 1); a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL fmt%0d_latency got out_valid=%b required=1", i, a_out_valid); end
      total++; if (a_out !== ve[i])      begin bad++; $display("FAIL fmt%0d_out got=%h required=%h", i, a_out, ve[i]); end
      total++; if (a_imm_err !== vr[i])  begin bad++; $display("FAIL fmt%0d_err got=%b required=%b", i, a_imm_err, vr[i]); end
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] w;
    w = 32'h800000B7;
    b_in = w[31:7]; b_src = IMM_U; b_in_tag = 5'd3; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    total++; if ({b_out_valid, b_imm_err, b_out_tag} !== {1'b1, 1'b0, 5'd3})
      begin bad++; $display("FAIL x64_u_flags got=%b/%b/%0d required=1/0/3", b_out_valid, b_imm_err, b_out_tag); end
    total++; if (b_out !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL x64_u_out got=%h required=ffffffff80000000", b_out); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    b_in = 25'h1FFFFFF; b_src = 3'b101; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    total++; if (b_out !== 64'h0)     begin bad++; $display("FAIL x64_bad_out got=%h required=0", b_out); end
    total++; if (b_imm_err !== 1'b1)  begin bad++; $display("FAIL x64_bad_err got=%b required=1", b_imm_err); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL x64_empty got=%b required=0", b_out_valid); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in = 25'($urandom); a_src = 3'd1; a_in_tag = 5'd1;
    tick();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b required=1", a_in_ready); end
    a_in = 25'($urandom); a_src = 3'd2; a_in_tag = 5'd2;
    tick();
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b required=0", a_in_ready); end
    a_in = 25'($urandom); a_src = 3'd3; a_in_tag = 5'd3;
    tick();
    total++; if ({a_in_ready, a_out_tag} !== {1'b0, 5'd1})
      begin bad++; $display("FAIL b2b_held got ready=%b tag=%0d required ready=0 tag=1", a_in_ready, a_out_tag); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    total++; if ({a_in_ready, a_out_tag} !== {1'b1, 5'd2})
      begin bad++; $display("FAIL b2b_after_pop got ready=%b tag=%0d required ready=1 tag=2", a_in_ready, a_out_tag); end
    tick();
    a_in_valid = 1'b0;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_third got=%b required=0", a_in_ready); end
    drain_a();
  endtask

  task automatic test_stream();
    int p0;
    p0 = pops;
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in = 25'($urandom); a_src = 3'(i % 6); a_in_tag = 5'(i);
      tick();
      total++; if ({a_out_valid, a_out_tag} !== {1'b1, 5'(i)})
        begin bad++; $display("FAIL stream%0d got valid=%b tag=%0d required valid=1 tag=%0d", i, a_out_valid, a_out_tag, i); end
    end
    a_in_valid = 1'b0;
    tick();
    a_out_ready = 1'b0;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b required=0", a_out_valid); end
    total++; if (pops - p0 !== 8) begin bad++; $display("FAIL stream_count got=%0d required=8", pops - p0); end
  endtask

  task automatic test_flush_rst();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in = 25'($urandom); a_src = 3'd0; a_in_tag = 5'd10;
    tick();
    a_in_tag = 5'd11;
    tick();
    a_in_tag = 5'd12; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    total++; if ({a_out_valid, a_in_ready} !== 2'b01)
      begin bad++; $display("FAIL flush_full got valid=%b ready=%b required 0/1", a_out_valid, a_in_ready); end
    a_in_valid = 1'b1; a_in_tag = 5'd13;
    tick();
    a_in_tag = 5'd14; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b required=0", a_out_valid); end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_stays got=%b required=0", a_out_valid); end
    a_in_valid = 1'b1; a_in_tag = 5'd20;
    tick();
    a_in_tag = 5'd21;
    tick();
    a_in_tag = 5'd22; a_rst = 1'b1;
    tick();
    a_rst = 1'b0; a_in_valid = 1'b0;
    total++; if ({a_out_valid, a_in_ready, a_imm_err, a_out_tag, a_out} !== {1'b0, 1'b1, 1'b0, 5'd0, 32'd0})
      begin bad++; $display("FAIL rst_mid got valid=%b ready=%b tag=%0d out=%h required 0/1/0/0", a_out_valid, a_in_ready, a_out_tag, a_out); end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_stays got=%b required=0", a_out_valid); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_back_to_back();
    test_stream();
    test_flush_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
